// File: rtl/bw_io_cmos2_pad_ctl.sv
// Drive sequencer for one shared bidirectional CMOS2 sideband pad: round-robin
// ownership, bus turnaround, por_l gating and a glitch-filtered receive path.
module bw_io_cmos2_pad_ctl #(
  parameter int TA_CYC   = 2,
  parameter int FILT_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic por_l,
  input  logic req0,
  input  logic req1,
  input  logic wdata0,
  input  logic wdata1,
  output logic gnt0,
  output logic gnt1,
  output logic pad_oe,
  output logic pad_data,
  input  logic pad_rx,
  output logic rx_data,
  output logic rx_chg,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  localparam logic [3:0] TA_LOAD  = 4'(TA_CYC);
  localparam logic [3:0] FILT_LIM = 4'(FILT_CYC);

  state_t     state, state_nxt;
  logic       por_s1, por_ok;
  logic       last, last_nxt;
  logic [3:0] ta_cnt, ta_cnt_nxt;
  logic       gnt0_nxt, gnt1_nxt, pad_oe_nxt, pad_data_nxt, busy_nxt;
  logic       win, owner_req, owner_wdata;
  logic       rx_s1, rs;
  logic [3:0] filt_cnt;

  // On a tie the requester that did not own the pad last time wins.
  assign win         = (req0 && req1) ? ~last : req1;
  assign owner_req   = last ? req1 : req0;
  assign owner_wdata = last ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      por_s1 <= 1'b0;
      por_ok <= 1'b0;
    end else begin
      por_s1 <= por_l;
      por_ok <= por_s1;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    ta_cnt_nxt   = ta_cnt;
    gnt0_nxt     = 1'b0;
    gnt1_nxt     = 1'b0;
    pad_oe_nxt   = 1'b0;
    pad_data_nxt = 1'b0;
    if (!por_ok) begin
      state_nxt  = IDLE;
      ta_cnt_nxt = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state_nxt    = DRIVE;
            last_nxt     = win;
            gnt0_nxt     = ~win;
            gnt1_nxt     = win;
            pad_oe_nxt   = 1'b1;
            pad_data_nxt = win ? wdata1 : wdata0;
          end
        end
        DRIVE: begin
          if (owner_req) begin
            gnt0_nxt     = ~last;
            gnt1_nxt     = last;
            pad_oe_nxt   = 1'b1;
            pad_data_nxt = owner_wdata;
          end else begin
            state_nxt  = TURN;
            ta_cnt_nxt = TA_LOAD;
          end
        end
        TURN: begin
          if (ta_cnt <= 4'd1) begin
            state_nxt  = IDLE;
            ta_cnt_nxt = 4'd0;
          end else begin
            ta_cnt_nxt = ta_cnt - 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      ta_cnt   <= 4'd0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      pad_oe   <= 1'b0;
      pad_data <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      ta_cnt   <= ta_cnt_nxt;
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
      pad_oe   <= pad_oe_nxt;
      pad_data <= pad_data_nxt;
      busy     <= busy_nxt;
    end
  end

  // A new receive level is accepted only after FILT_CYC consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b0;
      rs       <= 1'b0;
      filt_cnt <= 4'd0;
      rx_data  <= 1'b0;
      rx_chg   <= 1'b0;
    end else begin
      rx_s1  <= pad_rx;
      rs     <= rx_s1;
      rx_chg <= 1'b0;
      if (rs != rx_data) begin
        if (filt_cnt + 4'd1 == FILT_LIM) begin
          rx_data  <= rs;
          rx_chg   <= 1'b1;
          filt_cnt <= 4'd0;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_bw_io_cmos2_pad_ctl.sv
// Directed self-checking bench for bw_io_cmos2_pad_ctl (TA_CYC = 2, FILT_CYC = 3).
module tb_bw_io_cmos2_pad_ctl;

  logic clk = 1'b0;
  logic rst, por_l, req0, req1, wdata0, wdata1, pad_rx;
  logic gnt0, gnt1, pad_oe, pad_data, rx_data, rx_chg, busy;
  int   checks = 0;
  int   errors = 0;

  bw_io_cmos2_pad_ctl #(.TA_CYC(2), .FILT_CYC(3)) dut (
    .clk(clk), .rst(rst), .por_l(por_l),
    .req0(req0), .req1(req1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .pad_oe(pad_oe), .pad_data(pad_data),
    .pad_rx(pad_rx), .rx_data(rx_data), .rx_chg(rx_chg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; por_l = 1'b1; req0 = 1'b0; req1 = 1'b0;
    wdata0 = 1'b0; wdata1 = 1'b0; pad_rx = 1'b0;
    step; step;
    checks++;
    if ({gnt0, gnt1, pad_oe, pad_data, rx_data, rx_chg, busy} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %b expected 0000000",
               {gnt0, gnt1, pad_oe, pad_data, rx_data, rx_chg, busy});
    end
    #2 rst = 1'b0;
    por_l = 1'b0; req0 = 1'b1; wdata0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if ({gnt0, pad_oe, busy} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL por_block: gnt0/pad_oe/busy=%b expected 000", {gnt0, pad_oe, busy});
      end
    end
    por_l = 1'b1;
    step; step;
    checks++;
    if (gnt0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL por_early_grant: gnt0=%b expected 0", gnt0);
    end
    step;
    checks++;
    if ({gnt0, gnt1, pad_oe, pad_data, busy} !== 5'b10111) begin
      errors++;
      $display("[TB] FAIL por_release_grant: gnt0/gnt1/oe/data/busy=%b expected 10111",
               {gnt0, gnt1, pad_oe, pad_data, busy});
    end
    req0 = 1'b0;
    step;
    checks++;
    if ({gnt0, pad_oe, pad_data, busy} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL release_turn: gnt0/oe/data/busy=%b expected 0001",
               {gnt0, pad_oe, pad_data, busy});
    end
    step; step;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL turn_to_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single_owner;
    logic [4:0] wseq;
    wseq = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      req0 = 1'b1;
      wdata0 = wseq[4-i];
      step;
      checks++;
      if ({gnt0, pad_oe, pad_data} !== {2'b11, wseq[4-i]}) begin
        errors++;
        $display("[TB] FAIL single_drive[%0d]: gnt0/oe/data=%b expected %b",
                 i, {gnt0, pad_oe, pad_data}, {2'b11, wseq[4-i]});
      end
    end
    req0 = 1'b0;
    step;
    checks++;
    if ({gnt0, pad_oe, pad_data, busy} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_turn1: gnt0/oe/data/busy=%b expected 0001",
               {gnt0, pad_oe, pad_data, busy});
    end
    step;
    checks++;
    if ({pad_oe, busy} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_turn2: oe/busy=%b expected 01", {pad_oe, busy});
    end
    step;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: busy=%b expected 0", busy);
    end
  endtask

  // Requester 0 owned the pad last, so the first tie goes to requester 1.
  task automatic test_tie_fairness;
    int owner;
    int gap;
    req0 = 1'b1; req1 = 1'b1; wdata0 = 1'b0; wdata1 = 1'b1;
    owner = 1;
    step;
    checks++;
    if ({gnt1, gnt0} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL tie_first: gnt1/gnt0=%b expected 10", {gnt1, gnt0});
    end
    for (int w = 0; w < 3; w++) begin
      step; step;
      checks++;
      if ({gnt1, gnt0, pad_oe, pad_data} !== {owner == 1, owner == 0, 1'b1, owner == 1}) begin
        errors++;
        $display("[TB] FAIL tie_hold[%0d]: gnt1/gnt0/oe/data=%b owner %0d",
                 w, {gnt1, gnt0, pad_oe, pad_data}, owner);
      end
      if (owner == 1) req1 = 1'b0;
      else req0 = 1'b0;
      step;
      gap = (pad_oe === 1'b0) ? 1 : 0;
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 10 && pad_oe !== 1'b1; i++) begin
        step;
        if (pad_oe !== 1'b1) gap++;
      end
      checks++;
      if (gap != 3) begin
        errors++;
        $display("[TB] FAIL tie_gap[%0d]: idle cycles=%0d expected 3", w, gap);
      end
      owner = 1 - owner;
      checks++;
      if ({gnt1, gnt0} !== {owner == 1, owner == 0}) begin
        errors++;
        $display("[TB] FAIL tie_alternate[%0d]: gnt1/gnt0=%b expected owner %0d",
                 w, {gnt1, gnt0}, owner);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step; step; step; step;
    checks++;
    if ({busy, pad_oe} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL tie_cleanup: busy/oe=%b expected 00", {busy, pad_oe});
    end
  endtask

  task automatic test_por_abort;
    req1 = 1'b1; wdata1 = 1'b1;
    step; step;
    por_l = 1'b0;
    step; step;
    checks++;
    if ({gnt1, pad_oe} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL por_abort_sync: gnt1/oe=%b expected 11", {gnt1, pad_oe});
    end
    step;
    checks++;
    if ({gnt1, pad_oe, pad_data, busy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL por_abort_drop: gnt1/oe/data/busy=%b expected 0000",
               {gnt1, pad_oe, pad_data, busy});
    end
    step;
    checks++;
    if ({gnt1, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL por_abort_blocked: gnt1/busy=%b expected 00", {gnt1, busy});
    end
    req1 = 1'b0; por_l = 1'b1;
    step; step; step;
    // por falling at the same edge the owner lets go must skip turnaround.
    req0 = 1'b1;
    step;
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL por_sim_grant: gnt0=%b expected 1", gnt0);
    end
    por_l = 1'b0;
    step; step;
    req0 = 1'b0;
    step;
    checks++;
    if ({gnt0, pad_oe, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL por_sim_noturn: gnt0/oe/busy=%b expected 000", {gnt0, pad_oe, busy});
    end
    por_l = 1'b1;
    step; step; step;
  endtask

  task automatic test_filter;
    int chg_cnt;
    int hi_seen;
    chg_cnt = 0; hi_seen = 0;
    for (int e = 1; e <= 8; e++) begin
      pad_rx = (e <= 2);
      step;
      if (rx_chg === 1'b1) chg_cnt++;
      if (rx_data !== 1'b0) hi_seen++;
    end
    checks++;
    if (chg_cnt != 0 || hi_seen != 0) begin
      errors++;
      $display("[TB] FAIL filter_glitch: rx_chg pulses=%0d rx_data high cycles=%0d expected 0/0",
               chg_cnt, hi_seen);
    end
    for (int e = 1; e <= 6; e++) begin
      pad_rx = (e <= 4);
      step;
      if (e == 4) begin
        checks++;
        if ({rx_data, rx_chg} !== 2'b00) begin
          errors++;
          $display("[TB] FAIL filter_edge4: rx_data/rx_chg=%b expected 00", {rx_data, rx_chg});
        end
      end
      if (e == 5) begin
        checks++;
        if ({rx_data, rx_chg} !== 2'b11) begin
          errors++;
          $display("[TB] FAIL filter_edge5: rx_data/rx_chg=%b expected 11", {rx_data, rx_chg});
        end
      end
      if (e == 6) begin
        checks++;
        if ({rx_data, rx_chg} !== 2'b10) begin
          errors++;
          $display("[TB] FAIL filter_edge6: rx_data/rx_chg=%b expected 10", {rx_data, rx_chg});
        end
      end
    end
    for (int e = 0; e < 6; e++) step;
    checks++;
    if (rx_data !== 1'b0) begin
      errors++;
      $display("[TB] FAIL filter_return: rx_data=%b expected 0", rx_data);
    end
  endtask

  task automatic test_async_reset;
    req0 = 1'b1; wdata0 = 1'b1;
    step;
    checks++;
    if ({gnt0, pad_oe} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL areset_pre: gnt0/oe=%b expected 11", {gnt0, pad_oe});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt0, pad_oe, pad_data} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL areset_drop: gnt0/oe/data=%b expected 000", {gnt0, pad_oe, pad_data});
    end
    #1 rst = 1'b0;
    req0 = 1'b0; req1 = 1'b1;
    step; step;
    checks++;
    if (gnt1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_sync: gnt1=%b expected 0", gnt1);
    end
    step;
    checks++;
    if ({gnt1, gnt0} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL areset_sole_req1: gnt1/gnt0=%b expected 10", {gnt1, gnt0});
    end
    // After reset the pointer says requester 1 was last, so a tie favours requester 0.
    rst = 1'b1;
    #3 rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    step; step; step;
    checks++;
    if ({gnt1, gnt0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL areset_tie: gnt1/gnt0=%b expected 01", {gnt1, gnt0});
    end
    req0 = 1'b0; req1 = 1'b0;
    step; step; step;
  endtask

  initial begin
    test_reset;
    test_single_owner;
    test_tie_fairness;
    test_por_abort;
    test_filter;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
